// File: rtl/mem_axi_bridge_if.sv
// AXI4 single-beat bus between mem_axi_bridge (master) and the SDRAM AXI
// controller inport (slave). Only the channels the bridge drives or observes.
interface mem_axi_bridge_if;
  // Write address channel
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;
  // Write data channel
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wready;
  // Write response channel
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  // Read address channel
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  // Read data channel
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, awsize,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arburst, arsize,
    output rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst, awsize,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst, arsize,
    input  rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// Core valid/ready memory port to single-beat AXI4 master bridge.
// One transaction in flight; every AXI output comes straight from a register.
module mem_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_addr_i,
  input  logic [31:0]             mem_wdata_i,
  input  logic [3:0]              mem_wstrb_i,
  output logic                    mem_ready_o,
  output logic [31:0]             mem_rdata_o,
  output logic                    mem_err_o,
  mem_axi_bridge_if.master        outport
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_A,
    ST_RD_D
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q;
  logic        mem_err_q;

  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        ar_hs;
  logic        r_hs;
  logic        aw_done_d;
  logic        w_done_d;
  logic        b_err;
  logic        r_err;

  // Handshake detection and "channel finished, including this cycle" flags
  always_comb begin
    aw_hs     = awvalid_q & outport.awready;
    w_hs      = wvalid_q  & outport.wready;
    b_hs      = bready_q  & outport.bvalid;
    ar_hs     = arvalid_q & outport.arready;
    r_hs      = rready_q  & outport.rvalid;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q  | w_hs;
    // SLVERR (2'b10) and DECERR (2'b11) both have bit 1 set
    b_err     = (outport.bresp >= 2'b10);
    r_err     = (outport.rresp >= 2'b10);
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A request still high during the completion pulse is the old one
          if (mem_valid_i && !mem_ready_q) begin
            addr_q  <= mem_addr_i & 32'hFFFF_FFFC;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            if (mem_wstrb_i != '0) begin
              state_q   <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= ST_RD_A;
              arvalid_q <= 1'b1;
            end
          end
        end

        ST_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // B is only accepted once both AW and W have been handed over
          if (aw_done_d && w_done_d && !bready_q) begin
            bready_q <= 1'b1;
          end
          if (b_hs) begin
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            mem_ready_q <= 1'b1;
            mem_err_q   <= b_err;
            state_q     <= ST_IDLE;
          end
        end

        ST_RD_A: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_D;
          end
        end

        ST_RD_D: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            mem_rdata_q <= outport.rdata;
            mem_err_q   <= r_err;
            mem_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Core-side outputs
  assign mem_ready_o = mem_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_err_o   = mem_err_q;

  // AXI outputs, all from registers
  assign outport.awvalid = awvalid_q;
  assign outport.awaddr  = addr_q;
  assign outport.wvalid  = wvalid_q;
  assign outport.wdata   = wdata_q;
  assign outport.wstrb   = wstrb_q;
  assign outport.bready  = bready_q;
  assign outport.arvalid = arvalid_q;
  assign outport.araddr  = addr_q;
  assign outport.rready  = rready_q;

  // Fixed single-beat, 32-bit INCR attributes
  assign outport.awid    = AXI_ID;
  assign outport.awlen   = 8'd0;
  assign outport.awburst = 2'b01;
  assign outport.awsize  = 3'd2;
  assign outport.arid    = AXI_ID;
  assign outport.arlen   = 8'd0;
  assign outport.arburst = 2'b01;
  assign outport.arsize  = 3'd2;
  assign outport.wlast   = 1'b1;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: table of single transactions against a
// parameterised-delay AXI slave, plus reset-abort and back-to-back sequences.
module tb_mem_axi_bridge;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  mem_axi_bridge_if bus();

  mem_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_ready_o (mem_ready),
    .mem_rdata_o (mem_rdata),
    .mem_err_o   (mem_err),
    .outport     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    int          exp_ready_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_aw, exp_w, exp_b, exp_ar, exp_r, exp_bfirst;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // slave observation state
  int          cyc;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          bfirst, ready_cyc, pulses, bad_beats;
  logic        err_seen;
  logic [31:0] rdata_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
    input int aw_dly, input int w_dly, input int b_dly, input int ar_dly, input int r_dly,
    input logic [1:0] resp, input logic [31:0] rdata, input logic [31:0] exp_addr,
    input int exp_ready_cyc, input logic exp_err, input logic [31:0] exp_rdata,
    input int exp_aw, input int exp_w, input int exp_b, input int exp_ar, input int exp_r,
    input int exp_bfirst);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw_dly = aw_dly; v.w_dly = w_dly; v.b_dly = b_dly; v.ar_dly = ar_dly; v.r_dly = r_dly;
    v.resp = resp; v.rdata = rdata; v.exp_addr = exp_addr;
    v.exp_ready_cyc = exp_ready_cyc; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    v.exp_aw = exp_aw; v.exp_w = exp_w; v.exp_b = exp_b; v.exp_ar = exp_ar; v.exp_r = exp_r;
    v.exp_bfirst = exp_bfirst;
    return v;
  endfunction

  task automatic slave_idle();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
  endtask

  // Called at a negedge: observe this cycle, then set slave inputs for the coming edge
  task automatic slave_step(input vec_t v);
    if (bus.awvalid) begin
      aw_cnt++;
      if (bus.awaddr !== v.exp_addr) bad_beats++;
    end
    if (bus.wvalid) begin
      w_cnt++;
      if (bus.wdata !== v.wdata || bus.wstrb !== v.wstrb) bad_beats++;
    end
    if (bus.bready) begin
      b_cnt++;
      if (bfirst < 0) bfirst = cyc;
    end
    if (bus.arvalid) begin
      ar_cnt++;
      if (bus.araddr !== v.exp_addr) bad_beats++;
    end
    if (bus.rready) r_cnt++;
    if (mem_ready) begin
      pulses++;
      if (ready_cyc < 0) begin
        ready_cyc  = cyc;
        err_seen   = mem_err;
        rdata_seen = mem_rdata;
      end
    end
    bus.awready = bus.awvalid && (aw_cnt > v.aw_dly);
    bus.wready  = bus.wvalid  && (w_cnt  > v.w_dly);
    bus.bvalid  = bus.bready  && (b_cnt  > v.b_dly);
    bus.bresp   = v.resp;
    bus.arready = bus.arvalid && (ar_cnt > v.ar_dly);
    bus.rvalid  = bus.rready  && (r_cnt  > v.r_dly);
    bus.rdata   = v.rdata;
    bus.rresp   = v.resp;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb;
    cyc = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bfirst = -1; ready_cyc = -1; pulses = 0; bad_beats = 0;
    err_seen = 1'bx; rdata_seen = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      slave_step(v);
      if (ready_cyc >= 0) mem_valid = 1'b0;
      cyc++;
      if (ready_cyc >= 0 && cyc > ready_cyc + 2) break;
    end
    mem_valid = 1'b0;
    slave_idle();
    check({tag, "_ready_cyc"}, ready_cyc, v.exp_ready_cyc);
    check({tag, "_pulses"},    pulses,    1);
    check({tag, "_err"},       {31'd0, err_seen}, {31'd0, v.exp_err});
    check({tag, "_rdata"},     rdata_seen, v.exp_rdata);
    check({tag, "_aw_cycles"}, aw_cnt, v.exp_aw);
    check({tag, "_w_cycles"},  w_cnt,  v.exp_w);
    check({tag, "_b_cycles"},  b_cnt,  v.exp_b);
    check({tag, "_ar_cycles"}, ar_cnt, v.exp_ar);
    check({tag, "_r_cycles"},  r_cnt,  v.exp_r);
    check({tag, "_bfirst"},    bfirst, v.exp_bfirst);
    check({tag, "_bad_beats"}, bad_beats, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    vec_t vrd;
    int   seen;
    int   rpulses;
    int   ar_hs_cnt;
    int   pc[3];

    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    slave_idle();

    //          addr          wdata         strb     aw w b ar r  resp   rdata         exp_addr      rdy err exp_rdata     aw w b ar r bfirst
    vecs[0] = mk(32'h1000_0006, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'h1000_0004, 3, 0, 32'hDEADBEEF, 0, 0, 0, 1, 1, -1);
    vecs[1] = mk(32'h2000_0010, 32'h11223344, 4'b0011, 3, 0, 0, 0, 0, 2'b00, 32'h0,        32'h2000_0010, 6, 0, 32'hDEADBEEF, 4, 1, 1, 0, 0, 5);
    vecs[2] = mk(32'h3000_0003, 32'hCAFEF00D, 4'b1111, 0, 2, 0, 0, 0, 2'b10, 32'h0,        32'h3000_0000, 5, 1, 32'hDEADBEEF, 1, 3, 1, 0, 0, 4);
    vecs[3] = mk(32'h4000_0008, 32'h0,        4'b0000, 0, 0, 0, 0, 5, 2'b11, 32'h0BADC0DE, 32'h4000_0008, 8, 1, 32'h0BADC0DE, 0, 0, 0, 1, 6, -1);
    vecs[4] = mk(32'hFFFF_FFFF, 32'h0,        4'b0000, 0, 0, 0, 2, 0, 2'b00, 32'h12345678, 32'hFFFF_FFFC, 5, 0, 32'h12345678, 0, 0, 0, 3, 1, -1);
    vecs[5] = mk(32'h0000_0001, 32'h89ABCDEF, 4'b1000, 1, 1, 2, 0, 0, 2'b01, 32'h0,        32'h0000_0000, 6, 0, 32'h12345678, 2, 2, 3, 0, 0, 3);
    vecs[6] = mk(32'h5000_000C, 32'h55AA55AA, 4'b0100, 0, 0, 0, 0, 0, 2'b11, 32'h0,        32'h5000_000C, 3, 1, 32'h12345678, 1, 1, 1, 0, 0, 2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_awvalid", {31'd0, bus.awvalid}, 0);
    check("reset_wvalid",  {31'd0, bus.wvalid},  0);
    check("reset_bready",  {31'd0, bus.bready},  0);
    check("reset_arvalid", {31'd0, bus.arvalid}, 0);
    check("reset_rready",  {31'd0, bus.rready},  0);
    check("reset_ready",   {31'd0, mem_ready},   0);
    check("reset_rdata",   mem_rdata, 0);
    check("reset_err",     {31'd0, mem_err},     0);
    check("reset_addr",    bus.awaddr, 0);
    check("const_awid",    {28'd0, bus.awid},    0);
    check("const_arid",    {28'd0, bus.arid},    0);
    check("const_len",     {16'd0, bus.awlen, bus.arlen}, 0);
    check("const_burst",   {28'd0, bus.awburst, bus.arburst}, 32'h5);
    check("const_size",    {26'd0, bus.awsize, bus.arsize}, 32'h12);
    check("const_wlast",   {31'd0, bus.wlast}, 1);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while awaiting R: transaction dropped, everything cleared
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h7000_0000; mem_wstrb = 4'b0000;
    bus.arready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rready) begin
        seen = 1;
        break;
      end
    end
    check("rst_mid_reached_rd_d", seen, 1);
    rst = 1'b1; mem_valid = 1'b0; bus.arready = 1'b0;
    @(negedge clk);
    check("rst_mid_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("rst_mid_ready",  {31'd0, mem_ready}, 0);
    check("rst_mid_rdata",  mem_rdata, 0);
    check("rst_mid_err",    {31'd0, mem_err}, 0);
    check("rst_mid_addr",   bus.araddr, 0);
    rst = 1'b0;
    rpulses = 0;
    bus.rvalid = 1'b1; bus.rdata = 32'hFEEDFACE;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_ready) rpulses++;
    end
    bus.rvalid = 1'b0;
    check("rst_mid_no_pulse", rpulses, 0);

    vrd = mk(32'h6000_0002, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hA5A55A5A,
             32'h6000_0000, 3, 0, 32'hA5A55A5A, 0, 0, 0, 1, 1, -1);
    run_txn("post_rst_read", vrd);

    // mem_valid held high across three reads
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h8000_0004; mem_wstrb = 4'b0000;
    cyc = 0; ar_hs_cnt = 0; rpulses = 0;
    pc[0] = -1; pc[1] = -1; pc[2] = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (rpulses < 3) pc[rpulses] = cyc;
        rpulses++;
        if (rpulses == 3) mem_valid = 1'b0;
      end
      bus.arready = bus.arvalid;
      if (bus.arvalid) ar_hs_cnt++;
      bus.rvalid = bus.rready;
      bus.rdata  = 32'h0000_0B2B;
      bus.rresp  = 2'b00;
      cyc++;
    end
    mem_valid = 1'b0;
    slave_idle();
    check("b2b_ar_handshakes", ar_hs_cnt, 3);
    check("b2b_pulses",        rpulses,   3);
    check("b2b_pulse0_cyc",    pc[0], 3);
    check("b2b_pulse1_cyc",    pc[1], 7);
    check("b2b_pulse2_cyc",    pc[2], 11);
    check("b2b_rdata",         mem_rdata, 32'h0000_0B2B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
